load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   MEM-stage access controller that sits directly upstream of Data_Memory.
//   Accepts one load/store request at a time from the EX/MEM stage.
//   Drives the word-wide memory port and performs read-modify-write for byte
//   and halfword stores. Returns sign/zero-extended load data.
//   Misaligned accesses are flagged and never reach memory.
// PARAMETERS
//   ADDR_W  32  width of the request and memory address
//   DATA_W  32  word width; fixed at 32, byte lanes derived from it
// PORTS
//   clk            in   1   rising-edge clock
//   reset_n        in   1   asynchronous, active-low reset
//   req_valid      in   1   request present
//   req_ready      out  1   unit can accept; high only in IDLE
//   req_write      in   1   1=store, 0=load
//   req_size       in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned   in   1   loads: 1=zero-extend, 0=sign-extend
//   req_addr       in   32  byte address
//   req_wdata      in   32  store data, right-justified
//   req_rd         in   5   destination register tag, echoed on resp
//   resp_valid     out  1   one-cycle response pulse
//   resp_rdata     out  32  extended load data; 0 for stores and faults
//   resp_rd        out  5   echoed tag
//   resp_misalign  out  1   access faulted (misaligned or illegal size)
//   mem_addr       out  32  {addr[31:2],2'b00}, held for the whole access
//   mem_read       out  1   MemRead; memory returns data combinationally
//   mem_write      out  1   MemWrite; memory commits at the next rising edge
//   mem_wdata      out  32  full word to write
//   mem_rdata      in   32  read_data from memory
// BEHAVIOUR
//   Reset: state=IDLE. resp_*, latched request and merge registers are 0.
//     mem_read and mem_write decode from state, so both are 0 immediately.
//   Byte lanes are little-endian: byte k of a word is bits [8k+7:8k].
//   FSM:
//     IDLE : req_ready=1. On req_valid, latch the request and branch:
//              fault -> RESP (misalign=1)
//              load -> LOAD; word store -> WRITE; sub-word store -> RMWR
//     LOAD : mem_read=1. Extract lane, extend, register into resp_rdata.
//            -> RESP
//     RMWR : mem_read=1. Merge store bytes into mem_rdata, register the
//            merged word. -> WRITE
//     WRITE: mem_write=1, mem_wdata=merged (or req_wdata for word stores).
//            -> RESP
//     RESP : resp_valid=1 for exactly one cycle, req_ready=0. -> IDLE
//   Fault: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
//     mem_read and mem_write stay 0. resp_rdata=0.
//   Latency from the accept edge to resp_valid high:
//     load 2 cycles; word store 2; sub-word store 3; fault 1.
//   Throughput: at most 1 request per (latency+1) cycles. No pipelining.
//   req_valid while not ready is ignored. The requester must hold it.
//   Lane select: byte uses addr[1:0]; half uses addr[1] (lane 0 or 2).
//   Reset mid-access aborts with no memory write. mem_write falls
//     asynchronously with reset_n, and no resp_valid is produced.
//   mem_read and mem_write are never high in the same cycle.
//   mem_write is high for exactly one cycle per store.
// STRUCTURE
//   Shared package mips_mem_pkg: SIZE_BYTE/HALF/WORD encodings,
//     lsu_state_t enum {IDLE,LOAD,RMWR,WRITE,RESP}, misalignment function.
//   Sub-module lsu_byte_lane: purely combinational.
//     extract(word, addr[1:0], size, unsigned) and merge(word, wdata, addr, size).
//     Reused by the future cache fill path.
// TESTING
//   1. Reset; lw 0x0 (mem[0]=10) -> resp_rdata=0x0000000A, 2 cycles after accept.
//   2. sw 0x4 0xDEADBEEF; lb 0x7 -> 0xFFFFFFDE; lbu 0x7 -> 0x000000DE;
//      lh 0x4 -> 0xFFFFBEEF.
//   3. sb 0x5 data 0x12 over 0xDEADBEEF -> word 0xDEAD12EF.
//      resp after 3 cycles; mem_write pulses once.
//   4. lw 0x2 and lh 0x3 -> resp_misalign=1, resp_rdata=0.
//      mem_read and mem_write never asserted.
//   5. reset_n low during RMWR of sb 0x4 -> no mem_write, word unchanged,
//      no resp_valid. req_ready=1 the first cycle after release.
//   6. req_valid held high for 10 cycles with 2 queued loads ->
//      second accepted only in the cycle after RESP, 2 resp pulses, tags echoed.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: size encodings, LSU states
// and the alignment rule used to decide whether an access may reach memory.
package mips_mem_pkg;

   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RMWR  = 3'd2,
      WRITE = 3'd3,
      RESP  = 3'd4
   } lsu_state_t;

   // An illegal size is treated the same as a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addr_lo[0];
         SIZE_WORD: bad = (addr_lo != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational little-endian lane logic: extracts and extends a load lane from a
// word, and merges store bytes into a word for read-modify-write.
module lsu_byte_lane
   import mips_mem_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] word,
   input  logic [DATA_W-1:0] wdata,
   input  logic [1:0]        addr_lo,
   input  logic [1:0]        size,
   input  logic              is_unsigned,
   output logic [DATA_W-1:0] ext_data,
   output logic [DATA_W-1:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[8*addr_lo +: 8];
      half_sel = word[16*addr_lo[1] +: 16];
      ext_data = '0;
      merged   = word;
      case (size)
         SIZE_BYTE: begin
            ext_data = is_unsigned ? {{(DATA_W-8){1'b0}}, byte_sel}
                                   : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            merged[8*addr_lo +: 8] = wdata[7:0];
         end
         SIZE_HALF: begin
            ext_data = is_unsigned ? {{(DATA_W-16){1'b0}}, half_sel}
                                   : {{(DATA_W-16){half_sel[15]}}, half_sel};
            merged[16*addr_lo[1] +: 16] = wdata[15:0];
         end
         SIZE_WORD: begin
            ext_data = word;
            merged   = wdata;
         end
         default: begin
            ext_data = '0;
            merged   = word;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage access controller in front of a word-wide data memory: one request at
// a time, read-modify-write for sub-word stores, extended load data on response.
module load_store_unit
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [4:0]        req_rd,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [4:0]        resp_rd,
   output logic              resp_misalign,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   lsu_state_t state, state_next;

   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        size_q;
   logic              unsigned_q;
   logic [DATA_W-1:0] merged_q;
   logic [DATA_W-1:0] ext_data;
   logic [DATA_W-1:0] merged;
   logic              fault;

   assign fault = is_misaligned(req_size, req_addr[1:0]);

   lsu_byte_lane #(.DATA_W(DATA_W)) u_lane (
      .word        (mem_rdata),
      .wdata       (merged_q),
      .addr_lo     (addr_q[1:0]),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .ext_data    (ext_data),
      .merged      (merged)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Memory strobes decode from state only, so reset drops them immediately.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (fault)                       state_next = RESP;
               else if (!req_write)             state_next = LOAD;
               else if (req_size == SIZE_WORD)  state_next = WRITE;
               else                             state_next = RMWR;
            end
         end
         LOAD: begin
            mem_read   = 1'b1;
            state_next = RESP;
         end
         RMWR: begin
            mem_read   = 1'b1;
            state_next = WRITE;
         end
         WRITE: begin
            mem_write  = 1'b1;
            state_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // merged_q starts as the raw store data so a word store can write it directly.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q        <= '0;
         size_q        <= SIZE_BYTE;
         unsigned_q    <= 1'b0;
         merged_q      <= '0;
         resp_rdata    <= '0;
         resp_rd       <= '0;
         resp_misalign <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q        <= req_addr;
                  size_q        <= req_size;
                  unsigned_q    <= req_unsigned;
                  merged_q      <= req_wdata;
                  resp_rd       <= req_rd;
                  resp_misalign <= fault;
                  resp_rdata    <= '0;
               end
            end
            LOAD:    resp_rdata <= ext_data;
            RMWR:    merged_q   <= merged;
            default: ;
         endcase
      end
   end

   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = merged_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-addressed reference memory.
module tb_load_store_unit;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        resp_misalign;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:63];
   logic [7:0]  ref_mem [0:255];

   int checks = 0;
   int errors = 0;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_write     (req_write),
      .req_size      (req_size),
      .req_unsigned  (req_unsigned),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_rd        (req_rd),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_rd       (resp_rd),
      .resp_misalign (resp_misalign),
      .mem_addr      (mem_addr),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, write committed at the rising edge.
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 1'b1;
      if (sz == 2'd1) return a[0];
      if (sz == 2'd2) return a[1:0] != 2'b00;
      return 1'b0;
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
      logic [31:0] v;
      int n;
      n = nbytes(sz);
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) % 256]) << (8 * i));
      if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   function automatic logic [31:0] ref_word(input int w);
      return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
   endfunction

   task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      int lat, nr, nw, exp_lat, exp_nr;
      logic ov, flt;
      logic [31:0] exp_data;
      flt = ref_fault(sz, a);
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd; req_rd = rd;
      chk("ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1; nr = 0; nw = 0; ov = 1'b0;
      while (1) begin
         if (mem_read) nr++;
         if (mem_write) nw++;
         if (mem_read && mem_write) ov = 1'b1;
         if (resp_valid || lat >= 10) break;
         @(posedge clk); #1;
         lat++;
      end
      chk("resp_seen", 32'(resp_valid), 32'd1);
      if (flt)                exp_lat = 1;
      else if (!w)            exp_lat = 2;
      else if (sz == 2'd2)    exp_lat = 2;
      else                    exp_lat = 3;
      exp_nr   = (!flt && (!w || sz != 2'd2)) ? 1 : 0;
      exp_data = (!flt && !w) ? ref_load(a, sz, u) : 32'd0;
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("rdata", resp_rdata, exp_data);
      chk("rd_tag", 32'(resp_rd), 32'(rd));
      chk("misalign", 32'(resp_misalign), 32'(flt));
      chk("rd_pulses", 32'(nr), 32'(exp_nr));
      chk("wr_pulses", 32'(nw), 32'((w && !flt) ? 1 : 0));
      chk("rd_wr_overlap", 32'(ov), 32'd0);
      chk("ready_in_resp", 32'(req_ready), 32'd0);
      if (w && !flt)
         for (int i = 0; i < nbytes(sz); i++) ref_mem[(a + i) % 256] = wd[8*i +: 8];
      @(posedge clk); #1;
      chk("resp_one_cycle", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      logic        rdy;
      int          acc [2];
      int          na, nresp;
      logic [4:0]  tags [2];
      logic [31:0] qaddr [2];
      logic [1:0]  sz;
      logic [31:0] a;
      logic        w;

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
      ref_mem[0] = 8'd10; ref_mem[1] = 8'd0; ref_mem[2] = 8'd0; ref_mem[3] = 8'd0;
      for (int i = 0; i < 64; i++) mem[i] = ref_word(i);

      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_mem_write", 32'(mem_write), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_misalign", 32'(resp_misalign), 32'd0);
      @(negedge clk); reset_n = 1'b1;

      // Directed scenarios
      do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 5'd1);
      chk("lw0_value", ref_load(32'h0, 2'd2, 1'b0), 32'h0000_000A);
      do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'hDEAD_BEEF, 5'd2);
      do_req(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, 5'd3);
      do_req(1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 5'd4);
      do_req(1'b0, 2'd1, 1'b0, 32'h4, 32'h0, 5'd5);
      do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_0012, 5'd6);
      chk("sb_merge_word", mem[1], 32'hDEAD_12EF);
      do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, 5'd7);
      do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 5'd8);
      do_req(1'b1, 2'd3, 1'b0, 32'h8, 32'h1234_5678, 5'd9);

      // Reset during the read phase of a sub-word store
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h4;
      req_wdata = 32'h55; req_rd = 5'd10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("abort_in_rmwr", 32'(mem_read), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_mem_write", 32'(mem_write), 32'd0);
      chk("abort_resp", 32'(resp_valid), 32'd0);
      @(negedge clk); reset_n = 1'b1;
      chk("abort_ready_release", 32'(req_ready), 32'd1);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         chk("abort_no_write", 32'(mem_write), 32'd0);
         chk("abort_no_resp", 32'(resp_valid), 32'd0);
      end
      chk("abort_word_kept", mem[1], 32'hDEAD_12EF);

      // Two back-to-back loads with req_valid held
      tags[0] = 5'd17; tags[1] = 5'd18;
      qaddr[0] = 32'h8; qaddr[1] = 32'hC;
      na = 0; nresp = 0; acc[0] = -1; acc[1] = -1;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = qaddr[0]; req_rd = tags[0];
      for (int c = 0; c < 10; c++) begin
         rdy = req_ready;
         @(posedge clk); #1;
         if (rdy && req_valid && na < 2) begin acc[na] = c; na++; end
         if (resp_valid) begin
            if (nresp < 2) begin
               chk("queue_tag", 32'(resp_rd), 32'(tags[nresp]));
               chk("queue_data", resp_rdata, ref_load(qaddr[nresp], 2'd2, 1'b0));
            end
            nresp++;
         end
         @(negedge clk);
         if (na == 1) begin req_addr = qaddr[1]; req_rd = tags[1]; end
         if (na == 2) req_valid = 1'b0;
      end
      chk("queue_accepts", 32'(na), 32'd2);
      chk("queue_spacing", 32'(acc[1] - acc[0]), 32'd3);
      chk("queue_resps", 32'(nresp), 32'd2);

      // Randomized traffic, biased toward aligned accesses
      for (int n = 0; n < 80; n++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         w = 1'($urandom_range(0, 1));
         do_req(w, sz, 1'($urandom_range(0, 1)), a, $urandom, 5'($urandom));
      end

      for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_word(i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
